// File: rtl/general_reg_file.sv
// general_reg_file: parametrised register bank with bus/secondary writes,
// addressed inc/dec, two combinational read ports and a registered wrap pulse.
// Define GENERAL_REG_SAT_EN for saturating inc/dec instead of modulo wrap.
module general_reg_file #(
  parameter int WIDTH     = 16,
  parameter int NREGS     = 4,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_we,
  input  logic [AW-1:0]    bus_addr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             sec_we,
  input  logic [AW-1:0]    sec_addr,
  input  logic [WIDTH-1:0] sec_in,
  input  logic             inc,
  input  logic             dec,
  input  logic [AW-1:0]    id_addr,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wrap_q;
  logic             wrap_d;

  logic             step_en;
  logic [WIDTH-1:0] id_val;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   dif_x;
  logic             crossed;
  logic [WIDTH-1:0] step_val;

  // inc and dec together cancel out
  assign step_en = inc ^ dec;

  always_comb begin
    id_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (id_addr == AW'(i)) id_val = regs_q[i];
    end
  end

  // One adder/subtractor shared by all registers; borrow/carry in bit WIDTH
  always_comb begin
    sum_x   = {1'b0, id_val} + STEP_X;
    dif_x   = {1'b0, id_val} - STEP_X;
    crossed = inc ? sum_x[WIDTH] : dif_x[WIDTH];
`ifdef GENERAL_REG_SAT_EN
    if (crossed) begin
      step_val = inc ? '1 : '0;
    end else begin
      step_val = inc ? sum_x[WIDTH-1:0]
                     : dif_x[WIDTH-1:0];
    end
`else
    step_val = inc ? sum_x[WIDTH-1:0]
                   : dif_x[WIDTH-1:0];
`endif
  end

  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus_we && bus_addr == AW'(i)) begin
        regs_d[i] = bus_in;
      end else if (sec_we && sec_addr == AW'(i)) begin
        regs_d[i] = sec_in;
      end else if (step_en && id_addr == AW'(i)) begin
        regs_d[i] = step_val;
        wrap_d    = crossed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RST_W;
      end
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  // Out-of-range addresses match no register and read as zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_a_addr == AW'(i)) rd_a = regs_q[i];
      if (rd_b_addr == AW'(i)) rd_b = regs_q[i];
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_general_reg_file.sv
// tb_general_reg_file: table-driven vectors on a 4x16 STEP=1 bank plus
// hand sequences for async reset and a 3x16 STEP=4 RESET_VAL=7 bank.
module tb_general_reg_file;

`ifdef GENERAL_REG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        bus_we, sec_we, inc, dec, wrap;
  logic [1:0]  bus_addr, sec_addr, id_addr;
  logic [1:0]  rd_a_addr, rd_b_addr;
  logic [15:0] bus_in, sec_in, rd_a, rd_b;

  logic        a_bus_we, a_sec_we, a_inc, a_dec, a_wrap;
  logic [1:0]  a_bus_addr, a_sec_addr, a_id_addr;
  logic [1:0]  a_rd_a_addr, a_rd_b_addr;
  logic [15:0] a_bus_in, a_sec_in, a_rd_a, a_rd_b;

  general_reg_file #(
    .WIDTH(16), .NREGS(4), .STEP(1), .RESET_VAL(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_in(bus_in),
    .sec_we(sec_we), .sec_addr(sec_addr), .sec_in(sec_in),
    .inc(inc), .dec(dec), .id_addr(id_addr),
    .rd_a_addr(rd_a_addr), .rd_a(rd_a),
    .rd_b_addr(rd_b_addr), .rd_b(rd_b),
    .wrap(wrap)
  );

  general_reg_file #(
    .WIDTH(16), .NREGS(3), .STEP(4), .RESET_VAL(7)
  ) u_alt (
    .clk(clk), .rst(rst),
    .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_in(a_bus_in),
    .sec_we(a_sec_we), .sec_addr(a_sec_addr), .sec_in(a_sec_in),
    .inc(a_inc), .dec(a_dec), .id_addr(a_id_addr),
    .rd_a_addr(a_rd_a_addr), .rd_a(a_rd_a),
    .rd_b_addr(a_rd_b_addr), .rd_b(a_rd_b),
    .wrap(a_wrap)
  );

  typedef struct {
    string       name;
    logic        bwe;
    logic [1:0]  ba;
    logic [15:0] bd;
    logic        swe;
    logic [1:0]  sa;
    logic [15:0] sd;
    logic        inc;
    logic        dec;
    logic [1:0]  ia;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ew;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic add(input string nm,
                     input logic bwe, input logic [1:0] ba,
                     input logic [15:0] bd,
                     input logic swe, input logic [1:0] sa,
                     input logic [15:0] sd,
                     input logic i, input logic d, input logic [1:0] ia,
                     input logic [1:0] ra, input logic [1:0] rb,
                     input logic [15:0] ea, input logic [15:0] eb,
                     input logic ew);
    vec_t v;
    v.name = nm; v.bwe = bwe; v.ba = ba; v.bd = bd;
    v.swe = swe; v.sa = sa; v.sd = sd;
    v.inc = i; v.dec = d; v.ia = ia;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ew = ew;
    tbl.push_back(v);
  endtask

  task automatic idle_main();
    bus_we = 0; sec_we = 0; inc = 0; dec = 0;
    bus_addr = 0; sec_addr = 0; id_addr = 0;
    bus_in = 0; sec_in = 0;
  endtask

  task automatic alt_op(input logic bwe, input logic [1:0] ba,
                        input logic [15:0] bd,
                        input logic swe, input logic [1:0] sa,
                        input logic [15:0] sd,
                        input logic i, input logic d,
                        input logic [1:0] ia);
    a_bus_we = bwe; a_bus_addr = ba; a_bus_in = bd;
    a_sec_we = swe; a_sec_addr = sa; a_sec_in = sd;
    a_inc = i; a_dec = d; a_id_addr = ia;
    @(posedge clk); #1;
    a_bus_we = 0; a_sec_we = 0; a_inc = 0; a_dec = 0;
  endtask

  task automatic alt_rd(input string nm, input logic [1:0] addr,
                        input logic [15:0] exp);
    a_rd_a_addr = addr;
    a_rd_b_addr = addr;
    #1;
    chk({nm, "_a"}, a_rd_a, exp);
    chk({nm, "_b"}, a_rd_b, exp);
  endtask

  localparam logic [15:0] W1 = SAT ? 16'hFFFF : 16'h0000;
  localparam logic [15:0] W2 = SAT ? 16'hFFFE : 16'hFFFF;
  localparam logic [15:0] W3 = SAT ? 16'h0000 : 16'hFFFF;
  localparam logic        DW = SAT ? 1'b0 : 1'b1;

  initial begin
    add("wr_same",   1,1,16'h1234, 1,2,16'hBEEF, 0,0,0, 1,2,
        16'h0000, 16'h0000, 0);
    add("wr_read",   0,0,0, 0,0,0, 0,0,0, 1,2,
        16'h1234, 16'hBEEF, 0);
    add("collide",   1,0,16'hAAAA, 1,0,16'h5555, 1,0,0, 0,3,
        16'h0000, 16'h0000, 0);
    add("set3",      1,3,16'hFFFF, 0,0,0, 0,0,0, 0,3,
        16'hAAAA, 16'h0000, 0);
    add("inc_max",   0,0,0, 0,0,0, 1,0,3, 0,3,
        16'hAAAA, 16'hFFFF, 0);
    add("inc_wrap",  0,0,0, 0,0,0, 0,0,0, 3,1,
        W1, 16'h1234, 1);
    add("dec",       0,0,0, 0,0,0, 0,1,3, 3,3, W1, W1, 0);
    add("dec_res",   0,0,0, 0,0,0, 0,0,0, 3,2,
        W2, 16'hBEEF, DW);
    add("both",      0,0,0, 0,0,0, 1,1,3, 3,3, W2, W2, 0);
    add("both_res",  0,0,0, 0,0,0, 0,0,0, 3,0,
        W2, 16'hAAAA, 0);
    add("clr3",      1,3,16'h0000, 0,0,0, 0,0,0, 3,3, W2, W2, 0);
    add("dec_zero",  0,0,0, 0,0,0, 0,1,3, 3,0,
        16'h0000, 16'hAAAA, 0);
    add("dec_wrap",  0,0,0, 0,0,0, 0,0,0, 3,3, W3, W3, 1);
    add("sec_inc",   0,0,0, 1,1,16'h0FFF, 1,0,1, 1,3,
        16'h1234, W3, 0);
    add("sec_res",   0,0,0, 0,0,0, 0,0,0, 1,0,
        16'h0FFF, 16'hAAAA, 0);
    add("split",     1,1,16'h5A5A, 0,0,0, 1,0,2, 2,1,
        16'hBEEF, 16'h0FFF, 0);
    add("split_res", 0,0,0, 0,0,0, 0,0,0, 2,1,
        16'hBEF0, 16'h5A5A, 0);
    add("dec0",      0,0,0, 0,0,0, 0,1,0, 0,2,
        16'hAAAA, 16'hBEF0, 0);
    add("dec0_res",  0,0,0, 0,0,0, 0,0,0, 0,3,
        16'hAAA9, W3, 0);
    add("set3b",     1,3,16'hFFFF, 0,0,0, 0,0,0, 3,0,
        W3, 16'hAAA9, 0);
    add("wr_inc",    1,3,16'h0001, 0,0,0, 1,0,3, 3,3,
        16'hFFFF, 16'hFFFF, 0);
    add("wr_inc_res",0,0,0, 0,0,0, 0,0,0, 3,1,
        16'h0001, 16'h5A5A, 0);

    rst = 1'b0;
    idle_main();
    rd_a_addr = 0; rd_b_addr = 0;
    a_bus_we = 0; a_sec_we = 0; a_inc = 0; a_dec = 0;
    a_bus_addr = 0; a_sec_addr = 0; a_id_addr = 0;
    a_bus_in = 0; a_sec_in = 0;
    a_rd_a_addr = 0; a_rd_b_addr = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rd_a_addr = 2'(k);
      rd_b_addr = 2'(3 - k);
      #1;
      chk("rst_rd_a", rd_a, 16'h0000);
      chk("rst_rd_b", rd_b, 16'h0000);
    end
    chk("rst_wrap", wrap, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      bus_we = tbl[i].bwe; bus_addr = tbl[i].ba; bus_in = tbl[i].bd;
      sec_we = tbl[i].swe; sec_addr = tbl[i].sa; sec_in = tbl[i].sd;
      inc = tbl[i].inc; dec = tbl[i].dec; id_addr = tbl[i].ia;
      rd_a_addr = tbl[i].ra; rd_b_addr = tbl[i].rb;
      @(negedge clk);
      chk({tbl[i].name, "_rd_a"}, rd_a, tbl[i].ea);
      chk({tbl[i].name, "_rd_b"}, rd_b, tbl[i].eb);
      chk({tbl[i].name, "_wrap"}, wrap, tbl[i].ew);
    end
    @(posedge clk); #1;
    idle_main();

    // Async reset asserted mid-cycle while a wrap pulse is live
    bus_we = 1; bus_addr = 3; bus_in = 16'hFFFF;
    @(posedge clk); #1;
    bus_addr = 1; bus_in = 16'h1111;
    inc = 1; id_addr = 3;
    @(posedge clk); #1;
    idle_main();
    rd_a_addr = 1;
    #1;
    chk("pre_rst_wrap", wrap, 1'b1);
    chk("pre_rst_r1", rd_a, 16'h1111);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_wrap", wrap, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rd_a_addr = 2'(k);
      rd_b_addr = 2'(3 - k);
      #1;
      chk("mid_rst_rd_a", rd_a, 16'h0000);
      chk("mid_rst_rd_b", rd_b, 16'h0000);
    end
    bus_we = 1; bus_addr = 2; bus_in = 16'hBBBB;
    inc = 1; id_addr = 0;
    @(posedge clk); #1;
    rd_a_addr = 2; rd_b_addr = 0;
    #1;
    chk("hold_rst_r2", rd_a, 16'h0000);
    chk("hold_rst_r0", rd_b, 16'h0000);
    chk("hold_rst_wrap", wrap, 1'b0);
    idle_main();
    rst = 1'b1;
    @(posedge clk); #1;

    // NREGS=3, STEP=4, RESET_VAL=7 instance
    alt_rd("alt_rst0", 0, 16'h0007);
    alt_rd("alt_rst2", 2, 16'h0007);
    alt_rd("alt_oor_rd", 3, 16'h0000);
    chk("alt_rst_wrap", a_wrap, 1'b0);
    alt_op(1,3,16'h1234, 1,3,16'h4321, 0,0,0);
    alt_rd("alt_oor_wr", 3, 16'h0000);
    alt_rd("alt_oor_r0", 0, 16'h0007);
    alt_rd("alt_oor_r1", 1, 16'h0007);
    alt_op(1,0,16'h0002, 0,0,0, 1,0,3);
    chk("alt_oor_inc_wrap", a_wrap, 1'b0);
    alt_rd("alt_oor_inc_r2", 2, 16'h0007);
    alt_rd("alt_set0", 0, 16'h0002);
    alt_op(0,0,0, 0,0,0, 0,1,0);
    chk("alt_dec_wrap", a_wrap, 1'b1);
    alt_rd("alt_dec", 0, SAT ? 16'h0000 : 16'hFFFE);
    alt_op(0,0,0, 0,0,0, 0,0,0);
    chk("alt_wrap_pulse", a_wrap, 1'b0);
    alt_op(1,0,16'hFFFB, 0,0,0, 0,0,0);
    alt_op(0,0,0, 0,0,0, 1,0,0);
    chk("alt_inc_top_wrap", a_wrap, 1'b0);
    alt_rd("alt_inc_top", 0, 16'hFFFF);
    alt_op(0,0,0, 0,0,0, 1,0,0);
    chk("alt_inc_ovf_wrap", a_wrap, 1'b1);
    alt_rd("alt_inc_ovf", 0, SAT ? 16'hFFFF : 16'h0003);
    alt_op(0,0,0, 1,2,16'hFFFD, 0,0,0);
    alt_op(0,0,0, 0,0,0, 1,0,2);
    chk("alt_inc2_wrap", a_wrap, 1'b1);
    alt_rd("alt_inc2", 2, SAT ? 16'hFFFF : 16'h0001);
    alt_rd("alt_inc2_r1", 1, 16'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
